// File: rtl/wr_packer_pkg.sv
// wr_packer shared definitions: unit/word geometry and the unit-insert helper
// used by both the write-side packer and the read-side unpacker.
package wr_packer_pkg;

  localparam int MAX_UNITS = 32;
  localparam int UNIT_W    = 8;
  localparam int WORD_W    = MAX_UNITS * UNIT_W;
  localparam int PTR_W     = $clog2(MAX_UNITS);

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [2*WORD_W-1:0] dword_t;
  typedef logic [PTR_W-1:0]    ptr_t;

  // Units above ptr in acc are always zero, so OR-ing the shifted group is enough.
  function automatic dword_t unit_insert(
    input dword_t acc,
    input word_t  data,
    input ptr_t   units,
    input ptr_t   ptr
  );
    word_t  mask;
    dword_t ins;
    mask = ~({WORD_W{1'b1}} << (int'(units) * UNIT_W));
    ins  = dword_t'(data & mask) << (int'(ptr) * UNIT_W);
    return acc | ins;
  endfunction

endpackage

// File: rtl/wr_packer_edge.sv
// wr_packer_edge: single-flop rising-edge detector for sync inputs.
module wr_packer_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk_in) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/wr_packer.sv
// wr_packer: packs variable-width unit groups gap-free into FIFO words.
// Define WR_PACKER_FLUSH_EN to emit the partial word on a VS_I rising edge.
module wr_packer
  import wr_packer_pkg::*;
#(
  parameter int C_MAX_UNIT_NUM     = MAX_UNITS,
  parameter int C_BIT_NUM_PER_UNIT = UNIT_W
) (
  input  logic                                         clk_in,
  input  logic                                         rst,
  input  logic                                         VS_I,
  input  logic                                         DE_I,
  input  logic [$clog2(C_MAX_UNIT_NUM)-1:0]            UNITS_I,
  input  logic [C_MAX_UNIT_NUM*C_BIT_NUM_PER_UNIT-1:0] DATA_I,
  input  logic                                         FULL_I,
  output logic                                         WR_O,
  output logic [C_MAX_UNIT_NUM*C_BIT_NUM_PER_UNIT-1:0] DATA_O,
  output logic                                         OVF_O
);

  if (C_MAX_UNIT_NUM != MAX_UNITS || C_BIT_NUM_PER_UNIT != UNIT_W) begin : g_geom
    $error("wr_packer geometry must match wr_packer_pkg");
  end

  logic       vs_rise;
  ptr_t       units_q;
  ptr_t       ptr_q;
  word_t      hi_q;
  word_t      lo_q;
  logic       wr_q;
  word_t      data_q;
  logic       ovf_q;

  ptr_t       ptr_b;
  ptr_t       ptr_n;
  dword_t     acc_b;
  dword_t     acc_ins;
  dword_t     acc_n;
  logic [PTR_W:0] sum;
  logic       emit;
  word_t      emit_word;
  logic       wr_n;
  logic       ovf_n;

  wr_packer_edge u_vs_edge (
    .clk_in (clk_in),
    .rst    (rst),
    .sig    (VS_I),
    .rise   (vs_rise)
  );

  always_comb begin
    ptr_b     = ptr_q;
    acc_b     = {hi_q, lo_q};
    acc_ins   = acc_b;
    sum       = '0;
    emit      = 1'b0;
    emit_word = lo_q;
    ovf_n     = ovf_q;
    if (vs_rise) begin
`ifdef WR_PACKER_FLUSH_EN
      emit  = (ptr_q != '0);
`else
      emit  = 1'b0;
`endif
      ptr_b = '0;
      acc_b = '0;
      ovf_n = 1'b0;
    end
    ptr_n = ptr_b;
    acc_n = acc_b;
    if (DE_I) begin
      acc_ins = unit_insert(acc_b, DATA_I, units_q, ptr_b);
      sum     = {1'b0, ptr_b} + {1'b0, units_q};
      ptr_n   = sum[PTR_W-1:0];
      if (sum[PTR_W]) begin
        emit      = 1'b1;
        emit_word = acc_ins[WORD_W-1:0];
        acc_n     = {word_t'(0), acc_ins[2*WORD_W-1:WORD_W]};
      end else begin
        acc_n = acc_ins;
      end
    end
    wr_n = emit & ~FULL_I;
    if (emit && FULL_I) ovf_n = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      units_q <= UNITS_I;
      ptr_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (VS_I) units_q <= UNITS_I;
      ptr_q <= ptr_n;
      hi_q  <= acc_n[2*WORD_W-1:WORD_W];
      lo_q  <= acc_n[WORD_W-1:0];
      wr_q  <= wr_n;
      if (wr_n) data_q <= emit_word;
      ovf_q <= ovf_n;
    end
  end

  assign WR_O   = wr_q;
  assign DATA_O = data_q;
  assign OVF_O  = ovf_q;

endmodule

// File: tb/tb_wr_packer.sv
// tb_wr_packer: directed and random stimulus against a unit-queue model.
module tb_wr_packer;

  localparam int MAXU = 32;
  localparam int BPU  = 8;
  localparam int W    = MAXU * BPU;

  logic         clk_in = 1'b0;
  logic         rst;
  logic         VS_I;
  logic         DE_I;
  logic [4:0]   UNITS_I;
  logic [W-1:0] DATA_I;
  logic         FULL_I;
  logic         WR_O;
  logic [W-1:0] DATA_O;
  logic         OVF_O;

  int checks   = 0;
  int failures = 0;

  wr_packer #(.C_MAX_UNIT_NUM(MAXU), .C_BIT_NUM_PER_UNIT(BPU)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .VS_I    (VS_I),
    .DE_I    (DE_I),
    .UNITS_I (UNITS_I),
    .DATA_I  (DATA_I),
    .FULL_I  (FULL_I),
    .WR_O    (WR_O),
    .DATA_O  (DATA_O),
    .OVF_O   (OVF_O)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Model: the stream is a queue of units; a word leaves when 32 are queued.
  logic [BPU-1:0] q[$];
  int             m_units = 0;
  bit             m_vs    = 1'b0;
  bit             chk_en  = 1'b0;
  logic           exp_wr  = 1'b0;
  logic           exp_ovf = 1'b0;
  logic [W-1:0]   exp_data = '0;
  logic [W-1:0]   m_word;
  bit             m_emit;

  always @(posedge clk_in) begin
    if (rst) begin
      q.delete();
      m_units  = int'(UNITS_I);
      m_vs     = 1'b0;
      exp_wr   = 1'b0;
      exp_ovf  = 1'b0;
      exp_data = '0;
      chk_en   = 1'b1;
    end else begin
      m_emit = 1'b0;
      m_word = '0;
      exp_wr = 1'b0;
      if (VS_I && !m_vs) begin
`ifdef WR_PACKER_FLUSH_EN
        if (q.size() != 0) begin
          m_emit = 1'b1;
          for (int k = 0; k < q.size(); k++) m_word[k*BPU +: BPU] = q[k];
        end
`endif
        q.delete();
        exp_ovf = 1'b0;
      end
      if (DE_I) begin
        for (int k = 0; k < m_units; k++) q.push_back(DATA_I[k*BPU +: BPU]);
        if (q.size() >= MAXU) begin
          m_emit = 1'b1;
          for (int k = 0; k < MAXU; k++) m_word[k*BPU +: BPU] = q.pop_front();
        end
      end
      if (m_emit) begin
        if (FULL_I) exp_ovf = 1'b1;
        else begin
          exp_wr   = 1'b1;
          exp_data = m_word;
        end
      end
      m_vs = VS_I;
      if (VS_I) m_units = int'(UNITS_I);
    end
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("wr", W'(WR_O), W'(exp_wr));
      chk("ovf", W'(OVF_O), W'(exp_ovf));
      chk("data", DATA_O, exp_data);
    end
  end

  int cnt;

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
  endtask

  task automatic de_cycle(input int u, input logic full = 1'b0);
    DATA_I = {8{$urandom()}};
    for (int k = 0; k < u; k++) begin
      DATA_I[k*BPU +: BPU] = BPU'(cnt);
      cnt++;
    end
    DE_I   = 1'b1;
    FULL_I = full;
    step();
    DE_I   = 1'b0;
    FULL_I = 1'b0;
  endtask

  task automatic new_frame(input int u);
    UNITS_I = 5'(u);
    VS_I    = 1'b1;
    step();
    step();
    VS_I    = 1'b0;
    step();
  endtask

  logic [W-1:0] lit;

  initial begin
    rst = 1'b1; VS_I = 1'b0; DE_I = 1'b0; FULL_I = 1'b0;
    UNITS_I = 5'd0; DATA_I = '0;
    step();
    chk("rst_wr", W'(WR_O), '0);
    chk("rst_data", DATA_O, '0);
    step();
    rst = 1'b0;
    step();

    // units=4: words after DE cycles 8 and 16
    new_frame(4);
    cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      de_cycle(4);
      if (i == 7) chk("t1_nowr", W'(WR_O), W'(0));
      if (i == 8) begin
        chk("t1_wr0", W'(WR_O), W'(1));
        chk("t1_b0", W'(DATA_O[7:0]), W'(0));
        chk("t1_b31", W'(DATA_O[255:248]), W'(31));
      end
      if (i == 16) begin
        chk("t1_wr1", W'(WR_O), W'(1));
        chk("t1_b32", W'(DATA_O[7:0]), W'(32));
        chk("t1_b63", W'(DATA_O[255:248]), W'(63));
      end
    end

    // units=3: straddling groups
    new_frame(3);
    cnt = 0;
    for (int i = 1; i <= 22; i++) begin
      de_cycle(3);
      if (i == 10 || i == 21) chk("t2_nowr", W'(WR_O), W'(0));
      if (i == 11) begin
        chk("t2_wr0", W'(WR_O), W'(1));
        chk("t2_b31", W'(DATA_O[255:248]), W'(31));
      end
      if (i == 22) begin
        chk("t2_wr1", W'(WR_O), W'(1));
        chk("t2_b32", W'(DATA_O[7:0]), W'(32));
        chk("t2_b63", W'(DATA_O[255:248]), W'(63));
      end
    end

    // partial word at frame boundary
    new_frame(3);
    cnt = 0;
    repeat (5) de_cycle(3);
    VS_I = 1'b1;
    step();
`ifdef WR_PACKER_FLUSH_EN
    lit = '0;
    for (int k = 0; k < 15; k++) lit[k*BPU +: BPU] = BPU'(k);
    chk("t3_flush_wr", W'(WR_O), W'(1));
    chk("t3_flush_data", DATA_O, lit);
`else
    chk("t3_noflush_wr", W'(WR_O), W'(0));
`endif
    step();
    VS_I = 1'b0;
    step();
    cnt = 0;
    for (int i = 1; i <= 11; i++) begin
      de_cycle(3);
      if (i == 11) begin
        chk("t3_next_wr", W'(WR_O), W'(1));
        chk("t3_next_b0", W'(DATA_O[7:0]), W'(0));
      end
    end

    // FIFO full drops a word, OVF sticky until next VS rise
    new_frame(4);
    cnt = 0;
    repeat (7) de_cycle(4);
    de_cycle(4, 1'b1);
    chk("t4_drop_wr", W'(WR_O), W'(0));
    chk("t4_ovf", W'(OVF_O), W'(1));
    repeat (8) de_cycle(4);
    chk("t4_next_wr", W'(WR_O), W'(1));
    chk("t4_next_b32", W'(DATA_O[7:0]), W'(32));
    chk("t4_ovf_sticky", W'(OVF_O), W'(1));
    VS_I = 1'b1;
    step();
    chk("t4_ovf_clr", W'(OVF_O), W'(0));
    step();
    VS_I = 1'b0;
    step();

    // reset mid-line at ptr=20 with OVF set
    new_frame(4);
    cnt = 0;
    repeat (7) de_cycle(4);
    de_cycle(4, 1'b1);
    repeat (5) de_cycle(4);
    rst = 1'b1;
    step();
    chk("t5_wr", W'(WR_O), W'(0));
    chk("t5_data", DATA_O, '0);
    chk("t5_ovf", W'(OVF_O), W'(0));
    rst = 1'b0;
    new_frame(4);
    cnt = 100;
    repeat (8) de_cycle(4);
    chk("t5_first", W'(DATA_O[7:0]), W'(100));

    // mid-frame UNITS_I change ignored until VS
    new_frame(4);
    cnt = 0;
    repeat (2) de_cycle(4);
    UNITS_I = 5'd8;
    for (int i = 3; i <= 8; i++) begin
      de_cycle(8);
      if (i == 7) chk("t6_nowr", W'(WR_O), W'(0));
    end
    chk("t6_wr4", W'(WR_O), W'(1));
    chk("t6_b51", W'(DATA_O[255:248]), W'(51));
    new_frame(8);
    cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      de_cycle(8);
      if (i == 3) chk("t6_nowr8", W'(WR_O), W'(0));
    end
    chk("t6_wr8", W'(WR_O), W'(1));
    chk("t6_b31", W'(DATA_O[255:248]), W'(31));

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(499) == 0);
      if ($urandom_range(149) == 0) VS_I = ~VS_I;
      if ($urandom_range(19) == 0) UNITS_I = 5'($urandom_range(31));
      DE_I    = ($urandom_range(9) < 7);
      FULL_I  = ($urandom_range(19) == 0);
      DATA_I  = {8{$urandom()}};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
